// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates a programmed number of signed 24-bit products
// from the Booth/Wallace multiplier into a signed ACC_W-bit sum. It tracks
// signed overflow stickily and holds the result until the consumer takes it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; accumulator holds the last result
// ACC   | accepting products; cnt holds the number still expected
// DONE  | result valid on acc_out/ovf; waiting for out_ready
module mac_accumulator #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [23:0]      p,
  input  logic             p_valid,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf_q, ovf_nxt;

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             take;

  // Sign-extend the product and form the candidate sum and its overflow bit.
  always_comb begin
    p_ext   = ACC_W'($signed(p));
    sum     = acc + p_ext;
    add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    take    = (state == ACC) && p_valid;
  end

  // State, remaining count, accumulator and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  // Next-state and datapath update; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    ovf_nxt   = ovf_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = len;
          state_nxt = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (take) begin
          acc_nxt = sum;
          ovf_nxt = ovf_q | add_ovf;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from state and registers only; p never reaches acc_out
  // combinationally, and p_ready does not depend on p_valid.
  always_comb begin
    p_ready   = (state == ACC);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    acc_out   = acc;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed, table-driven bench for mac_accumulator. Two instances share all
// inputs: dut_a (ACC_W=32) carries the ordinary checks, dut_b (ACC_W=26)
// carries the overflow scenario.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [23:0] p = '0;
  logic        p_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        p_ready_a, ovf_a, out_valid_a, busy_a;
  logic [31:0] acc_out_a;
  logic        p_ready_b, ovf_b, out_valid_b, busy_b;
  logic [25:0] acc_out_b;

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  mac_accumulator #(.ACC_W(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .p(p),
    .p_valid(p_valid), .p_ready(p_ready_a), .acc_out(acc_out_a),
    .ovf(ovf_a), .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a)
  );

  mac_accumulator #(.ACC_W(26), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .p(p),
    .p_valid(p_valid), .p_ready(p_ready_b), .acc_out(acc_out_b),
    .ovf(ovf_b), .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Count handshakes on dut_a as seen on the wire.
  always @(posedge clk) begin
    if (rst_n && p_valid && p_ready_a) accepts <= accepts + 1;
  end

  typedef struct {
    string            name;
    int               len;
    int               n;
    logic [0:7][23:0] prod;
    int               gap;
    longint           exp_acc;
    bit               exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l);
    start = 1'b1;
    len   = 8'(l);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy_a, 1);
  endtask

  task automatic send(input logic [23:0] v, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      p_valid = 1'b0;
      p       = 24'hABCDEF;
      tick();
    end
    p       = v;
    p_valid = 1'b1;
    n = 0;
    while (!p_ready_a && n < 8) begin
      tick();
      n++;
    end
    if (!p_ready_a) chk("p_ready_timeout", p_ready_a, 1);
    tick();
    p_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!out_valid_a && n < bound) begin
      tick();
      n++;
    end
    if (!out_valid_a) chk("out_valid_timeout", out_valid_a, 1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_after_handoff", out_valid_a, 0);
    chk("busy_after_handoff", busy_a, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    base = accepts;
    start_job(v.len);
    for (int i = 0; i < v.n; i++) send(v.prod[i], v.gap);
    chk({v.name, "_latency"}, out_valid_a, 1);
    wait_done(4);
    chk({v.name, "_acc"}, $signed(acc_out_a), v.exp_acc);
    chk({v.name, "_ovf"}, ovf_a, v.exp_ovf);
    chk({v.name, "_accepts"}, accepts - base, v.n);
    release_result();
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"basic", 3, 3, {24'd100, -24'sd50, 24'd7, 120'd0}, 0, 57, 1'b0};
    vecs[1] = '{"signext", 2, 2, {24'hC00000, 24'hFFFFFF, 144'd0}, 0, -4194305, 1'b0};
    vecs[2] = '{"stall", 4, 4, {24'd1, 24'd1, 24'hFFFFFF, 24'd1, 96'd0}, 1, 2, 1'b0};
    vecs[3] = '{"zero_len", 0, 0, {192'd0}, 0, 0, 1'b0};
    vecs[4] = '{"extremes", 4, 4, {24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'd1, 96'd0},
                2, 8388607, 1'b0};

    // Reset values
    #3;
    chk("rst_p_ready", p_ready_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_acc", acc_out_a, 0);
    chk("rst_ovf", ovf_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table vectors
    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: result held while out_ready stays low
    start_job(2);
    send(24'd40, 0);
    send(24'd2, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out_valid", out_valid_a, 1);
      chk("hold_acc", $signed(acc_out_a), 42);
    end
    release_result();

    // Start pulsed during ACC is ignored
    begin
      int base;
      base = accepts;
      start_job(3);
      send(24'd10, 0);
      start = 1'b1;
      len   = 8'd1;
      tick();
      start = 1'b0;
      chk("ign_start_busy", p_ready_a, 1);
      send(24'd20, 0);
      chk("ign_start_not_done", out_valid_a, 0);
      send(24'd30, 0);
      wait_done(4);
      chk("ign_start_acc", $signed(acc_out_a), 60);
      chk("ign_start_accepts", accepts - base, 3);
      release_result();
    end

    // Maximum length: 255 products back to back, counter must not wrap
    begin
      int base;
      base = accepts;
      start_job(255);
      p       = 24'd3;
      p_valid = 1'b1;
      for (int i = 0; i < 254; i++) tick();
      chk("maxlen_not_done", out_valid_a, 0);
      tick();
      p_valid = 1'b0;
      chk("maxlen_done", out_valid_a, 1);
      chk("maxlen_acc", $signed(acc_out_a), 765);
      chk("maxlen_accepts", accepts - base, 255);
      release_result();
    end

    // Overflow on the 26-bit instance
    start_job(9);
    for (int i = 0; i < 9; i++) send(24'd4194304, 0);
    wait_done(4);
    chk("ovf26_flag", ovf_b, 1);
    chk("ovf26_acc", $signed(acc_out_b), -29360128);
    chk("ovf26_valid", out_valid_b, 1);
    release_result();
    start_job(1);
    send(24'd5, 0);
    wait_done(4);
    chk("ovf26_cleared", ovf_b, 0);
    chk("ovf26_next_acc", $signed(acc_out_b), 5);
    release_result();

    // Asynchronous reset in the middle of a job
    start_job(5);
    send(24'd11, 0);
    send(24'd12, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_p_ready", p_ready_a, 0);
    chk("mid_rst_acc", acc_out_a, 0);
    chk("mid_rst_out_valid", out_valid_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_job(1);
    send(24'd9, 0);
    wait_done(4);
    chk("post_rst_acc", $signed(acc_out_a), 9);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
